// File: rtl/wb_arbiter.sv
// Writeback arbiter: two {tag,value} result FIFOs (ALU, LSB) merged into one registered ROB writeback port.
// Define WB_ARB_FIXED_PRIO_EN to give the LSB fixed priority instead of round-robin.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [31:0]      alu_value,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_value,
  output logic             alu_full,
  output logic             lsb_full,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_value,
  output logic             wb_src,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + 32;

  logic [1:0]            w_in_valid;
  logic [1:0]            w_full;
  logic [1:0]            w_nonempty;
  logic [1:0][ENT_W-1:0] w_in_data;
  logic [1:0][ENT_W-1:0] w_head;
  logic                  w_advance;
  logic                  w_any;
  logic                  w_grant;

  logic                  r_wb_valid;
  logic                  r_wb_src;
  logic [TAG_W-1:0]      r_wb_tag;
  logic [31:0]           r_wb_value;
  logic                  r_overflow;

  assign w_advance    = rdy_in & ~clear_in;
  assign w_in_valid   = {lsb_valid, alu_valid};
  assign w_in_data[0] = {alu_tag, alu_value};
  assign w_in_data[1] = {lsb_tag, lsb_value};

  // Source 0 = ALU, source 1 = LSB; full is taken from the pre-edge count, so a same-edge pop never frees a slot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_q
      logic [ENT_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_cnt;
      logic             w_push;
      logic             w_pop;

      assign w_full[gi]     = (r_cnt == CNT_W'(DEPTH));
      assign w_nonempty[gi] = (r_cnt != '0);
      assign w_head[gi]     = r_mem[r_rptr];
      assign w_push         = w_advance & w_in_valid[gi] & ~w_full[gi];
      assign w_pop          = w_advance & w_any & (w_grant == 1'(gi));

      always_ff @(posedge clk_in) begin
        if (w_push) begin
          r_mem[r_wptr] <= w_in_data[gi];
        end
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else if (rdy_in) begin
          if (clear_in) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
          end else begin
            r_wptr <= r_wptr + PTR_W'(w_push);
            r_rptr <= r_rptr + PTR_W'(w_pop);
            r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
          end
        end
      end
    end
  endgenerate

  assign w_any = |w_nonempty;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign w_grant = w_nonempty[1];
`else
  logic r_last_src;

  // Contended grants alternate; an uncontended source wins outright.
  assign w_grant = (&w_nonempty) ? ~r_last_src : w_nonempty[1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_src <= 1'b1;
    end else if (w_advance && w_any) begin
      r_last_src <= w_grant;
    end
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wb_valid <= 1'b0;
      r_wb_src   <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_value <= '0;
      r_overflow <= 1'b0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_wb_valid <= 1'b0;
      end else begin
        r_wb_valid <= w_any;
        if (w_any) begin
          r_wb_src               <= w_grant;
          {r_wb_tag, r_wb_value} <= w_head[w_grant];
        end
        if (|(w_in_valid & w_full)) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign alu_full = w_full[0];
  assign lsb_full = w_full[1];
  assign wb_valid = r_wb_valid;
  assign wb_src   = r_wb_src;
  assign wb_tag   = r_wb_tag;
  assign wb_value = r_wb_value;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int ENT_W = TAG_W + 32;

  logic             clk_in;
  logic             rst_in;
  logic             rdy_in;
  logic             clear_in;
  logic             alu_valid;
  logic [TAG_W-1:0] alu_tag;
  logic [31:0]      alu_value;
  logic             lsb_valid;
  logic [TAG_W-1:0] lsb_tag;
  logic [31:0]      lsb_value;
  logic             alu_full;
  logic             lsb_full;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  logic             wb_src;
  logic             overflow;

  wb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
    .alu_full(alu_full), .lsb_full(lsb_full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_src(wb_src),
    .overflow(overflow)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per source, pop chosen from pre-edge occupancy, then pushes.
  logic [ENT_W-1:0] mq_alu[$];
  logic [ENT_W-1:0] mq_lsb[$];
  logic [ENT_W:0]   m_list[$];
  bit               m_last;
  bit               m_ovf;
  bit               m_wv;
  bit               m_ws;
  logic [ENT_W-1:0] m_wd;

  task automatic model_reset();
    mq_alu.delete();
    mq_lsb.delete();
    m_list.delete();
    m_last = 1'b1;
    m_ovf  = 1'b0;
    m_wv   = 1'b0;
    m_ws   = 1'b0;
    m_wd   = '0;
  endtask

  task automatic model_edge();
    bit af, lf, an, ln, g;
    if (!rdy_in) return;
    if (clear_in) begin
      mq_alu.delete();
      mq_lsb.delete();
      m_wv = 1'b0;
      return;
    end
    af = (mq_alu.size() == DEPTH);
    lf = (mq_lsb.size() == DEPTH);
    an = (mq_alu.size() != 0);
    ln = (mq_lsb.size() != 0);
`ifdef WB_ARB_FIXED_PRIO_EN
    g = ln;
`else
    g = (an && ln) ? !m_last : ln;
`endif
    m_wv = an || ln;
    if (m_wv) begin
      m_ws   = g;
      m_wd   = g ? mq_lsb.pop_front() : mq_alu.pop_front();
      m_last = g;
      m_list.push_back({g, m_wd});
    end
    if (alu_valid) begin
      if (af) m_ovf = 1'b1;
      else    mq_alu.push_back({alu_tag, alu_value});
    end
    if (lsb_valid) begin
      if (lf) m_ovf = 1'b1;
      else    mq_lsb.push_back({lsb_tag, lsb_value});
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    alu_valid = 1'b0;
    alu_tag   = '0;
    alu_value = '0;
    lsb_valid = 1'b0;
    lsb_tag   = '0;
    lsb_value = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [ENT_W+4:0] got;
    got = {wb_valid, wb_src, wb_tag, wb_value, alu_full, lsb_full, overflow};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h, expected all zero", got);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    alu_valid = 1'b1;
    alu_tag   = 5'd3;
    alu_value = 32'h55;
    tick();
    alu_valid = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge0: wb_valid=%b, expected 0", wb_valid);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_tag !== 5'd3 || wb_value !== 32'h55 || wb_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: valid=%b tag=%0d value=%h src=%b, expected 1 3 00000055 0",
               wb_valid, wb_tag, wb_value, wb_src);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge2: wb_valid=%b, expected 0", wb_valid);
    end
  endtask

  task automatic test_contention();
    int exp_src[8];
    int exp_tag[8];
    int got_n;
    logic [31:0] exp_val;
`ifdef WB_ARB_FIXED_PRIO_EN
    exp_src = '{1, 1, 1, 1, 0, 0, 0, 0};
    exp_tag = '{9, 10, 11, 12, 1, 2, 3, 4};
`else
    exp_src = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp_tag = '{1, 9, 2, 10, 3, 11, 4, 12};
`endif
    do_reset();
    got_n = 0;
    for (int i = 0; i < 12; i++) begin
      alu_valid = (i < 4);
      alu_tag   = TAG_W'(1 + i);
      alu_value = 32'hA000_0000 + 32'(i);
      lsb_valid = (i < 4);
      lsb_tag   = TAG_W'(9 + i);
      lsb_value = 32'hB000_0000 + 32'(i);
      tick();
      if (wb_valid) begin
        n_tests++;
        if (got_n >= 8) begin
          n_fail++;
          $display("FAIL contention_extra: unexpected writeback tag=%0d", wb_tag);
        end else begin
          exp_val = (exp_src[got_n] != 0) ? 32'hB000_0000 + 32'(exp_tag[got_n] - 9)
                                          : 32'hA000_0000 + 32'(exp_tag[got_n] - 1);
          if (wb_src !== exp_src[got_n][0] || wb_tag !== TAG_W'(exp_tag[got_n]) || wb_value !== exp_val) begin
            n_fail++;
            $display("FAIL contention[%0d]: got src=%0d tag=%0d value=%h, expected src=%0d tag=%0d value=%h",
                     got_n, wb_src, wb_tag, wb_value, exp_src[got_n], exp_tag[got_n], exp_val);
          end
        end
        got_n++;
      end
    end
    idle_inputs();
    n_tests++;
    if (got_n != 8) begin
      n_fail++;
      $display("FAIL contention_count: got %0d writebacks, expected 8", got_n);
    end
  endtask

  task automatic test_overflow();
    int alu_n;
    int alu_wb;
    int exp_alu_wb;
`ifdef WB_ARB_FIXED_PRIO_EN
    alu_n = 5;
`else
    alu_n = 10;
`endif
    do_reset();
    alu_wb = 0;
    for (int i = 0; i < alu_n + 24; i++) begin
      alu_valid = (i < alu_n);
      alu_tag   = TAG_W'(i + 1);
      alu_value = 32'hC000_0000 + 32'(i);
      lsb_valid = (i < alu_n);
      lsb_tag   = TAG_W'(16 + (i % 16));
      lsb_value = 32'hD000_0000 + 32'(i);
      tick();
      if (wb_valid && wb_src == 1'b0) alu_wb++;
      n_tests++;
      if (alu_full !== (mq_alu.size() == DEPTH) || lsb_full !== (mq_lsb.size() == DEPTH) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL overflow_cycle%0d: alu_full=%b lsb_full=%b overflow=%b, expected %b %b %b",
                 i, alu_full, lsb_full, overflow, mq_alu.size() == DEPTH, mq_lsb.size() == DEPTH, m_ovf);
      end
`ifdef WB_ARB_FIXED_PRIO_EN
      if (i == 3) begin
        n_tests++;
        if (alu_full !== 1'b1) begin
          n_fail++;
          $display("FAIL overflow_full_after_4: alu_full=%b, expected 1", alu_full);
        end
      end
`endif
    end
    idle_inputs();
    exp_alu_wb = 0;
    foreach (m_list[k]) if (m_list[k][ENT_W] == 1'b0) exp_alu_wb++;
`ifdef WB_ARB_FIXED_PRIO_EN
    exp_alu_wb = 4;
`endif
    n_tests++;
    if (overflow !== 1'b1 || alu_wb != exp_alu_wb) begin
      n_fail++;
      $display("FAIL overflow_final: overflow=%b alu_writebacks=%0d, expected 1 and %0d", overflow, alu_wb, exp_alu_wb);
    end
  endtask

  task automatic test_flush();
    int late_wb;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_tag   = TAG_W'(i + 1);
      alu_value = 32'(i);
      lsb_valid = 1'b1;
      lsb_tag   = TAG_W'(i + 9);
      lsb_value = 32'(i + 100);
      tick();
    end
    alu_valid = 1'b0;
    clear_in  = 1'b1;
    lsb_valid = 1'b1;
    lsb_tag   = 5'h1E;
    tick();
    idle_inputs();
    n_tests++;
    if (wb_valid !== 1'b0 || alu_full !== 1'b0 || lsb_full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_edge: wb_valid=%b alu_full=%b lsb_full=%b, expected 0 0 0", wb_valid, alu_full, lsb_full);
    end
    late_wb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_valid) late_wb++;
    end
    n_tests++;
    if (late_wb != 0) begin
      n_fail++;
      $display("FAIL flush_late: got %0d writebacks after flush, expected 0", late_wb);
    end
  endtask

  task automatic test_stall();
    bit               sa[6];
    bit               sl[6];
    logic [TAG_W-1:0] st[6];
    logic [31:0]      sv[6];
    logic [ENT_W:0]   ref_list[$];
    logic [ENT_W:0]   dut_list[$];
    logic [ENT_W+1:0] exp_v;
    logic [ENT_W+1:0] got_v;
    int               seq_i;
    for (int i = 0; i < 6; i++) begin
      sa[i] = ($urandom_range(0, 3) != 0);
      sl[i] = ($urandom_range(0, 3) != 0);
      st[i] = TAG_W'($urandom);
      sv[i] = $urandom;
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alu_valid = (i < 6) ? sa[i] : 1'b0;
      alu_tag   = (i < 6) ? st[i] : '0;
      alu_value = (i < 6) ? sv[i] : '0;
      lsb_valid = (i < 6) ? sl[i] : 1'b0;
      lsb_tag   = (i < 6) ? ~st[i] : '0;
      lsb_value = (i < 6) ? ~sv[i] : '0;
      tick();
    end
    ref_list = m_list;

    do_reset();
    seq_i = 0;
    for (int c = 0; c < 25; c++) begin
      rdy_in = !(c >= 2 && c < 7);
      if (rdy_in) begin
        alu_valid = (seq_i < 6) ? sa[seq_i] : 1'b0;
        alu_tag   = (seq_i < 6) ? st[seq_i] : '0;
        alu_value = (seq_i < 6) ? sv[seq_i] : '0;
        lsb_valid = (seq_i < 6) ? sl[seq_i] : 1'b0;
        lsb_tag   = (seq_i < 6) ? ~st[seq_i] : '0;
        lsb_value = (seq_i < 6) ? ~sv[seq_i] : '0;
        seq_i++;
      end else begin
        alu_valid = 1'($urandom);
        alu_tag   = TAG_W'($urandom);
        lsb_valid = 1'($urandom);
        lsb_tag   = TAG_W'($urandom);
      end
      tick();
      if (rdy_in && wb_valid) dut_list.push_back({wb_src, wb_tag, wb_value});
      if (!rdy_in) begin
        exp_v = m_wv ? {1'b1, m_ws, m_wd} : '0;
        got_v = wb_valid ? {1'b1, wb_src, wb_tag, wb_value} : '0;
        n_tests++;
        if (got_v !== exp_v || alu_full !== (mq_alu.size() == DEPTH) || lsb_full !== (mq_lsb.size() == DEPTH)) begin
          n_fail++;
          $display("FAIL stall_frozen_c%0d: got wb=%h full=%b%b, expected wb=%h", c, got_v, lsb_full, alu_full, exp_v);
        end
      end
    end
    idle_inputs();
    n_tests++;
    if (dut_list.size() != ref_list.size()) begin
      n_fail++;
      $display("FAIL stall_order_len: got %0d writebacks, expected %0d", dut_list.size(), ref_list.size());
    end else begin
      foreach (ref_list[k]) begin
        if (dut_list[k] !== ref_list[k]) begin
          n_fail++;
          $display("FAIL stall_order[%0d]: got %h, expected %h", k, dut_list[k], ref_list[k]);
          break;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int late_wb;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      alu_valid = 1'b1;
      alu_tag   = TAG_W'($urandom);
      alu_value = $urandom;
      lsb_valid = 1'b1;
      lsb_tag   = TAG_W'($urandom);
      lsb_value = $urandom;
      tick();
    end
    idle_inputs();
    n_tests++;
    if (overflow !== m_ovf || alu_full !== (mq_alu.size() == DEPTH) || lsb_full !== (mq_lsb.size() == DEPTH)) begin
      n_fail++;
      $display("FAIL areset_pre: overflow=%b alu_full=%b lsb_full=%b, expected %b %b %b",
               overflow, alu_full, lsb_full, m_ovf, mq_alu.size() == DEPTH, mq_lsb.size() == DEPTH);
    end
    #3;
    rst_in = 1'b1;
    #1;
    n_tests++;
    if (wb_valid !== 1'b0 || alu_full !== 1'b0 || lsb_full !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: wb_valid=%b alu_full=%b lsb_full=%b overflow=%b, expected 0 0 0 0",
               wb_valid, alu_full, lsb_full, overflow);
    end
    #1;
    rst_in = 1'b0;
    model_reset();
    late_wb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_valid) late_wb++;
    end
    n_tests++;
    if (late_wb != 0) begin
      n_fail++;
      $display("FAIL areset_drain: got %0d writebacks after reset, expected 0", late_wb);
    end
  endtask

  task automatic test_random();
    logic [ENT_W+1:0] exp_v;
    logic [ENT_W+1:0] got_v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      clear_in  = ($urandom_range(0, 39) == 0);
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_tag   = TAG_W'($urandom);
      alu_value = $urandom;
      lsb_valid = ($urandom_range(0, 9) < 5);
      lsb_tag   = TAG_W'($urandom);
      lsb_value = $urandom;
      tick();
      exp_v = m_wv ? {1'b1, m_ws, m_wd} : '0;
      got_v = wb_valid ? {1'b1, wb_src, wb_tag, wb_value} : '0;
      n_tests++;
      if (got_v !== exp_v || alu_full !== (mq_alu.size() == DEPTH) ||
          lsb_full !== (mq_lsb.size() == DEPTH) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random_c%0d: wb=%h full=%b%b ovf=%b, expected wb=%h full=%b%b ovf=%b",
                 i, got_v, lsb_full, alu_full, overflow, exp_v,
                 mq_lsb.size() == DEPTH, mq_alu.size() == DEPTH, m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    model_reset();
    #12;
    rst_in = 1'b0;
    test_reset();
    test_single_push();
    test_contention();
    test_overflow();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, per-source result queue depth (power of two, 2..16).
REQ-002 The block SHALL have parameter TAG_W, default 5, ROB tag width (32-entry ROB).
REQ-003 The block SHALL have ports clk_in input 1, the single clock, and rst_in input 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port rdy_in input 1: global enable; when low, all state holds.
REQ-005 The block SHALL have port clear_in input 1: ROB flush from mispredict or jump commit.
REQ-006 The block SHALL have ports alu_valid input 1, alu_tag input TAG_W and alu_value input 32: ALU result for the ROB.
REQ-007 The block SHALL have ports lsb_valid input 1, lsb_tag input TAG_W and lsb_value input 32: LSB load result for the ROB.
REQ-008 The block SHALL have ports alu_full output 1 and lsb_full output 1: queue cannot accept.
REQ-009 The block SHALL have ports wb_valid output 1, wb_tag output TAG_W and wb_value output 32: single writeback to the ROB.
REQ-010 The block SHALL have port wb_src output 1: 0 = ALU, 1 = LSB.
REQ-011 The block SHALL have port overflow output 1: sticky flag, push dropped while full.

Function
REQ-012 The block SHALL keep one FIFO per source of DEPTH entries, each entry holding {tag, value}, with a read pointer, a write pointer and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-013 alu_full and lsb_full SHALL be combinational: asserted exactly when the count of that source equals DEPTH.
REQ-014 On a rising edge with rdy_in=1 and clear_in=0, a source with valid=1 and full=0 SHALL be written at its write pointer.
REQ-015 A push while full SHALL be dropped and SHALL set overflow; full is evaluated before any same-edge pop, so a push to a full queue is dropped even if that queue pops on the same edge.
REQ-016 On each rising edge with rdy_in=1 and clear_in=0, the block SHALL pop at most one entry across both queues into the wb_* registers; wb_valid=1 for that one cycle; if both queues are empty, wb_valid=0.
REQ-017 Arbitration SHALL be round-robin: a register last_src records the last granted source; when both queues are non-empty, the other source wins; when one queue is non-empty, it wins regardless of last_src.
REQ-018 Latency SHALL be 2 edges into an idle arbiter: valid sampled at edge N, wb_valid high in the cycle after edge N+1; there is no bypass path.
REQ-019 Simultaneous push and pop on the same queue SHALL leave the count unchanged; on an empty queue the push is stored and not popped on that edge.
REQ-020 Entries SHALL leave each queue in arrival order; tag and value SHALL be passed through unmodified.
REQ-021 clear_in=1 with rdy_in=1 SHALL, at the edge: empty both queues (pointers and counts to 0), discard that edge's inputs, set wb_valid to 0, and keep last_src and overflow.
REQ-022 rdy_in=0 SHALL freeze queues, pointers, last_src and the wb_* registers; inputs are ignored, and wb_valid keeps its value.

Reset
REQ-023 rst_in=1 SHALL asynchronously set pointers, counts, wb_valid, wb_tag, wb_value, wb_src and overflow to 0, and last_src to 1, so the first contended grant goes to the ALU.
REQ-024 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.

Configuration
REQ-025 With macro WB_ARB_FIXED_PRIO_EN defined, the LSB SHALL always win when both queues are non-empty, and last_src SHALL be removed.
REQ-026 Without WB_ARB_FIXED_PRIO_EN, the round-robin rule of REQ-017 SHALL apply.

Verification
REQ-027 Single push: alu_valid with tag 3, value 0x55 at edge 0 -> wb_valid=1, wb_tag=3, wb_value=0x55, wb_src=0 in the cycle after edge 1 only.
REQ-028 Contention: after reset, both sources push every edge (ALU tags 1,2,...; LSB tags 9,10,...) -> wb_src sequence 0,1,0,1 with in-order tags; with WB_ARB_FIXED_PRIO_EN defined -> LSB tags 9,10,... first.
REQ-029 Overflow: DEPTH=4, 5 ALU pushes with lsb busy and ALU blocked by continuous LSB pushes under fixed priority -> alu_full=1 after the 4th push, 5th dropped, overflow=1, and only 4 ALU writebacks are seen.
REQ-030 Flush: 3 entries queued, clear_in pulse together with an lsb push -> wb_valid=0 next cycle, both full=0, and no later writeback of the flushed or same-edge tags.
REQ-031 Stall: rdy_in=0 for 5 cycles with entries queued -> outputs frozen; on release, the writeback order is identical to the no-stall run.
REQ-032 Async reset: rst_in pulsed mid-cycle with queues non-empty -> wb_valid=0 and full=0 before the next edge, and overflow=0.
